// File: rtl/td4_run_ctrl.sv
// Run/step/breakpoint controller for the TD4 core: debounced KEY, short/long press
// classification, and a one-cycle CPU_CE from a rate divider (RUN) or per press (STEP).
module td4_run_ctrl #(
  parameter int unsigned DEB_CYCLES  = 270000,
  parameter int unsigned LONG_CYCLES = 13500000,
  parameter int unsigned DIV         = 8388608,
  parameter bit          START_RUN   = 1'b1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       KEY,
  input  logic [3:0] PC,
  input  logic       BP_EN,
  input  logic [3:0] BP_ADDR,
  output logic       CPU_CE,
  output logic [1:0] MODE,
  output logic       HIT,
  output logic       PRESSED,
  output logic [7:0] TICKS
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned DivW  = $clog2(DIV);

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [HoldW-1:0] LongLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] LongSat  = HoldW'(LONG_CYCLES);
  localparam logic [DivW-1:0]  DivLast  = DivW'(DIV - 1);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  localparam state_e StReset = START_RUN ? StRun : StHalt;

  logic             key_meta_q, key_sync_q;
  logic             pressed_q, pressed_d;
  logic             pressed_prev_q;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             armed_q, armed_d;
  logic             ce_q, ce_d;
  logic             hit_q, hit_d;
  logic [7:0]       ticks_q, ticks_d;

  logic sync_level;
  logic long_ev, short_ev;
  logic div_last, bp_cond;

  assign sync_level = ~key_sync_q;

  // Debounce and press classification
  always_comb begin
    pressed_d = pressed_q;
    deb_cnt_d = '0;
    if (sync_level != pressed_q) begin
      if (deb_cnt_q == DebLast) begin
        pressed_d = sync_level;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    hold_cnt_d = '0;
    if (pressed_q) begin
      hold_cnt_d = (hold_cnt_q == LongSat) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
  end

  // Hold count sits at LongSat once LONG has fired, which suppresses the release SHORT.
  assign long_ev  = pressed_q && (hold_cnt_q == LongLast);
  assign short_ev = pressed_prev_q && !pressed_q && (hold_cnt_q != LongSat);

  assign div_last = (div_q == DivLast);
  assign bp_cond  = div_last && armed_q && BP_EN && (PC == BP_ADDR);

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    hit_d   = hit_q;
    armed_d = (state_q == StRun) ? armed_q : 1'b0;
    div_d   = '0;

    unique case (state_q)
      StHalt: begin
        if (short_ev) begin
          state_d = StStep;
          ce_d    = 1'b1;
        end else if (long_ev) begin
          state_d = StRun;
        end
      end
      StRun: begin
        div_d = div_last ? '0 : div_q + 1'b1;
        // Press events take priority over the divider; HIT reflects only the breakpoint.
        if (short_ev || long_ev) begin
          state_d = StHalt;
          hit_d   = bp_cond;
        end else if (bp_cond) begin
          state_d = StHalt;
          hit_d   = 1'b1;
        end else if (div_last) begin
          ce_d    = 1'b1;
          armed_d = 1'b1;
        end
      end
      StStep: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    if (state_d != StRun) begin
      div_d = '0;
    end
    if (state_q == StHalt && state_d != StHalt) begin
      hit_d = 1'b0;
    end

    ticks_d = ce_d ? ticks_q + 8'd1 : ticks_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      key_meta_q     <= 1'b1;
      key_sync_q     <= 1'b1;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      state_q        <= StReset;
      div_q          <= '0;
      armed_q        <= 1'b0;
      ce_q           <= 1'b0;
      hit_q          <= 1'b0;
      ticks_q        <= 8'd0;
    end else begin
      key_meta_q     <= KEY;
      key_sync_q     <= key_meta_q;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_q;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      state_q        <= state_d;
      div_q          <= div_d;
      armed_q        <= armed_d;
      ce_q           <= ce_d;
      hit_q          <= hit_d;
      ticks_q        <= ticks_d;
    end
  end

  assign CPU_CE  = ce_q;
  assign MODE    = state_q;
  assign HIT     = hit_q;
  assign PRESSED = pressed_q;
  assign TICKS   = ticks_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl with DEB_CYCLES=4, LONG_CYCLES=20, DIV=8; one instance
// starts in RUN, the other in HALT and carries the key/breakpoint scenarios.
module tb_td4_run_ctrl;

  typedef struct packed {
    logic       key;
    logic       pressed;
    logic [1:0] mode;
    logic       ce;
    logic [7:0] ticks;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_run_n, rst_halt_n;
  logic       key_halt;
  logic [3:0] pc;
  logic       bp_en;
  logic [3:0] bp_addr;

  logic       r_ce, r_hit, r_pressed;
  logic [1:0] r_mode;
  logic [7:0] r_ticks;
  logic       h_ce, h_hit, h_pressed;
  logic [1:0] h_mode;
  logic [7:0] h_ticks;

  int   n_cmp;
  int   n_bad;
  logic prev_ce;
  vec_t vecs[$];

  always #5 clk = ~clk;

  td4_run_ctrl #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .DIV        (8),
    .START_RUN  (1'b1)
  ) dut_run (
    .CLK    (clk),
    .nRST   (rst_run_n),
    .KEY    (1'b1),
    .PC     (4'd0),
    .BP_EN  (1'b0),
    .BP_ADDR(4'd0),
    .CPU_CE (r_ce),
    .MODE   (r_mode),
    .HIT    (r_hit),
    .PRESSED(r_pressed),
    .TICKS  (r_ticks)
  );

  td4_run_ctrl #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20),
    .DIV        (8),
    .START_RUN  (1'b0)
  ) dut_halt (
    .CLK    (clk),
    .nRST   (rst_halt_n),
    .KEY    (key_halt),
    .PC     (pc),
    .BP_EN  (bp_en),
    .BP_ADDR(bp_addr),
    .CPU_CE (h_ce),
    .MODE   (h_mode),
    .HIT    (h_hit),
    .PRESSED(h_pressed),
    .TICKS  (h_ticks)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock; the bench PC advances on every CE of the HALT-start instance.
  task automatic tick();
    @(posedge clk);
    #1;
    if (h_ce) begin
      check("ce_not_back_to_back", 32'(prev_ce), 32'd0);
      pc = pc + 4'd1;
    end
    prev_ce = h_ce;
  endtask

  task automatic add_run(input logic key, input logic p, input logic [1:0] m, input logic c,
                         input logic [7:0] t, input int n);
    vec_t v;
    v.key = key; v.pressed = p; v.mode = m; v.ce = c; v.ticks = t;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic wait_mode(input logic [1:0] m, input int max_cycles, input string name);
    int i = 0;
    while (h_mode !== m && i < max_cycles) begin
      tick();
      i++;
    end
    check(name, 32'(h_mode), 32'(m));
  endtask

  task automatic wait_ce(input int max_cycles, input string name);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!h_ce && i < max_cycles);
    check(name, 32'(h_ce), 32'd1);
  endtask

  task automatic long_press();
    key_halt = 1'b0;
    repeat (30) tick();
    key_halt = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] t0;
    n_cmp = 0; n_bad = 0; prev_ce = 1'b0;
    key_halt = 1'b1; pc = 4'd0; bp_en = 1'b0; bp_addr = 4'd0;
    rst_run_n = 1'b0; rst_halt_n = 1'b0;

    // Bounce / step table: two 2-cycle glitches, then a 10-cycle press.
    add_run(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 2);
    add_run(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 4);
    add_run(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 2);
    add_run(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 4);
    add_run(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 5);
    add_run(1'b0, 1'b1, 2'b00, 1'b0, 8'd0, 5);
    add_run(1'b1, 1'b1, 2'b00, 1'b0, 8'd0, 5);
    add_run(1'b1, 1'b0, 2'b00, 1'b0, 8'd0, 1);
    add_run(1'b1, 1'b0, 2'b10, 1'b1, 8'd1, 1);
    add_run(1'b1, 1'b0, 2'b00, 1'b0, 8'd1, 3);

    repeat (3) tick();
    check("reset_halt", 32'({h_ce, h_hit, h_pressed, h_mode, h_ticks}), 32'd0);
    check("reset_run", 32'({r_ce, r_hit, r_pressed, r_mode, r_ticks}), 32'({5'b00001, 8'd0}));
    rst_run_n = 1'b1; rst_halt_n = 1'b1;

    for (int k = 1; k <= 40; k++) begin
      logic e_ce;
      tick();
      e_ce = (k % 8 == 0);
      check($sformatf("run_cadence_%0d", k), 32'({r_mode, r_ce, r_ticks}),
            32'({2'b01, e_ce, 8'(k / 8)}));
    end

    foreach (vecs[i]) begin
      key_halt = vecs[i].key;
      tick();
      check($sformatf("step_vec_%0d", i), 32'({h_pressed, h_mode, h_ce, h_ticks}),
            32'({vecs[i].pressed, vecs[i].mode, vecs[i].ce, vecs[i].ticks}));
    end

    // Long press from HALT: RUN after 25 edges, release gives no SHORT, CE every 8.
    for (int r = 0; r < 50; r++) begin
      logic [1:0] e_mode;
      logic       e_ce;
      logic [7:0] e_ticks;
      key_halt = (r < 30) ? 1'b0 : 1'b1;
      tick();
      e_mode  = (r >= 25) ? 2'b01 : 2'b00;
      e_ce    = (r >= 33) && ((r - 33) % 8 == 0);
      e_ticks = (r >= 33) ? 8'(1 + (r - 33) / 8 + 1) : 8'd1;
      check($sformatf("long_row_%0d", r), 32'({h_mode, h_ce, h_ticks}),
            32'({e_mode, e_ce, e_ticks}));
    end

    // Breakpoint at PC=3, then resume past it.
    rst_halt_n = 1'b0;
    repeat (2) tick();
    rst_halt_n = 1'b1;
    pc = 4'd0; bp_en = 1'b1; bp_addr = 4'd3;
    long_press();
    check("bp_run_after_long", 32'(h_mode), 32'd1);
    wait_mode(2'b00, 100, "bp_halt_reached");
    check("bp_hit_state", 32'({h_hit, pc, h_ticks}), 32'({1'b1, 4'd3, 8'd3}));
    repeat (20) tick();
    check("bp_holds", 32'({h_mode, h_hit, pc, h_ticks}), 32'({2'b00, 1'b1, 4'd3, 8'd3}));
    long_press();
    check("bp_resume", 32'({h_mode, h_hit}), 32'({2'b01, 1'b0}));
    wait_ce(20, "bp_first_ce");
    check("bp_past", 32'({pc, h_ticks}), 32'({4'd4, 8'd4}));

    // SHORT lands on divider count 7: no CE, HALT, TICKS unchanged.
    bp_en = 1'b0;
    wait_ce(20, "coll_sync");
    t0 = h_ticks;
    key_halt = 1'b0;
    repeat (9) tick();
    key_halt = 1'b1;
    repeat (6) tick();
    check("coll_pre", 32'({h_mode, h_pressed, h_ticks}), 32'({2'b01, 1'b0, t0 + 8'd1}));
    tick();
    check("coll_edge", 32'({h_mode, h_ce, h_hit, h_ticks}), 32'({2'b00, 1'b0, 1'b0, t0 + 8'd1}));

    // Reset during a held press: press is discarded.
    key_halt = 1'b0;
    repeat (8) tick();
    check("midrst_pressed", 32'(h_pressed), 32'd1);
    rst_halt_n = 1'b0;
    tick();
    check("midrst_halt_vals", 32'({h_ce, h_hit, h_pressed, h_mode, h_ticks}), 32'd0);
    key_halt = 1'b1;
    repeat (2) tick();
    rst_halt_n = 1'b1;
    repeat (20) tick();
    check("midrst_no_short", 32'({h_ce, h_pressed, h_mode, h_ticks}), 32'd0);

    // Reset during RUN: back to reset values, cadence restarts.
    rst_run_n = 1'b0;
    tick();
    check("midrst_run_vals", 32'({r_ce, r_hit, r_pressed, r_mode, r_ticks}),
          32'({5'b00001, 8'd0}));
    rst_run_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic e_ce;
      tick();
      e_ce = (k == 8);
      check($sformatf("midrst_run_cad_%0d", k), 32'({r_ce, r_ticks}), 32'({e_ce, 7'd0, e_ce}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
